// File: rtl/adder_pipe.sv
// adder_pipe: pipelined add/subtract unit with a registered carry between slices.
// The operand width DATA_W is cut into CHUNK-bit slices and each pipeline stage
// adds one slice, so one operation is accepted per clock when the consumer keeps up.
// Optional feature macro: ADDER_PIPE_SAT_EN. When it is defined, a signed overflow
// clamps the sum to the signed limit in the final stage. When it is not defined,
// the sum wraps modulo 2^DATA_W.
module adder_pipe #(
  parameter int DATA_W = 16,
  parameter int CHUNK  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic              cout,
  output logic              ovf
);

  localparam int STAGES = DATA_W / CHUNK;
  localparam int MSB    = DATA_W - 1;

`ifdef ADDER_PIPE_SAT_EN
  function automatic logic signed [DATA_W-1:0] sat_sum(
    input logic signed [DATA_W-1:0] raw,
    input logic                     ov,
    input logic                     a_msb
  );
    logic signed [DATA_W-1:0] res;
    res = raw;
    if (ov) begin
      res = a_msb ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
    return res;
  endfunction
`endif

  // Level k holds the operands entering slice stage k. Level 0 is the
  // accepted operand set.
  logic signed [DATA_W-1:0] a_p  [STAGES];
  logic signed [DATA_W-1:0] bx_p [STAGES];
  logic        [DATA_W-1:0] ps_p [STAGES];
  logic                     c_p  [STAGES];
  logic                     vld_p[STAGES];

  // The final stage drives the output registers.
  logic signed [DATA_W-1:0] sum_pf;
  logic                     cout_pf;
  logic                     ovf_pf;
  logic                     vld_pf;

  logic        [CHUNK:0]    slc[STAGES];
  logic        [DATA_W-1:0] nps[STAGES];
  logic                     nc [STAGES];

  logic                     adv;
  logic        [DATA_W-1:0] bx_in;
  logic                     c0_in;
  logic        [DATA_W-1:0] raw_l;
  logic                     ovf_l;
  logic signed [DATA_W-1:0] sum_l;

  assign adv      = ~vld_pf | out_ready;
  assign in_ready = rst_n & adv;
  assign bx_in    = sub ? ~b : b;
  assign c0_in    = sub | cin;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      slc[k] = {1'b0, a_p[k][k*CHUNK +: CHUNK]}
             + {1'b0, bx_p[k][k*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, c_p[k]};
      nps[k] = ps_p[k];
      nps[k][k*CHUNK +: CHUNK] = slc[k][CHUNK-1:0];
      nc[k]  = slc[k][CHUNK];
    end
  end

  always_comb begin
    raw_l = nps[STAGES-1];
    ovf_l = (a_p[STAGES-1][MSB] == bx_p[STAGES-1][MSB]) &
            (raw_l[MSB] != a_p[STAGES-1][MSB]);
`ifdef ADDER_PIPE_SAT_EN
    sum_l = sat_sum($signed(raw_l), ovf_l, a_p[STAGES-1][MSB]);
`else
    sum_l = $signed(raw_l);
`endif
  end

  // Accept boundary, then the slice stage boundaries. Data moves only on adv.
  always_ff @(posedge clk) begin
    if (adv) begin
      a_p[0]  <= $signed(a);
      bx_p[0] <= $signed(bx_in);
      ps_p[0] <= '0;
      c_p[0]  <= c0_in;
      for (int k = 1; k < STAGES; k++) begin
        a_p[k]  <= a_p[k-1];
        bx_p[k] <= bx_p[k-1];
        ps_p[k] <= nps[k-1];
        c_p[k]  <= nc[k-1];
      end
    end
  end

  // Valid bits and the output stage: reset empties the whole pipe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= 1'b0;
      end
      vld_pf  <= 1'b0;
      sum_pf  <= '0;
      cout_pf <= 1'b0;
      ovf_pf  <= 1'b0;
    end else if (adv) begin
      vld_p[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
      vld_pf  <= vld_p[STAGES-1];
      sum_pf  <= sum_l;
      cout_pf <= nc[STAGES-1];
      ovf_pf  <= ovf_l;
    end
  end

  assign out_valid = vld_pf;
  assign sum       = sum_pf;
  assign cout      = cout_pf;
  assign ovf       = ovf_pf;

endmodule
